// File: rtl/uart_dbg_pkg.sv
// ---------------------------------------------------------------------------
// uart_dbg_pkg
// Shared definitions for the UART debug command sequencer:
//   - command opcodes carried in bits [31:24] of the first command word
//   - status words returned to the host after every command
//   - the sequencer state encoding
// ---------------------------------------------------------------------------
package uart_dbg_pkg;

    localparam logic [7:0]  OP_PING        = 8'h00;
    localparam logic [7:0]  OP_READ        = 8'h01;
    localparam logic [7:0]  OP_WRITE       = 8'h02;

    localparam logic [31:0] ST_OK          = 32'h0000_0000;
    localparam logic [31:0] ST_BAD_OPCODE  = 32'h0000_0001;
    localparam logic [31:0] ST_BUS_TIMEOUT = 32'h0000_0002;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_BUS,
        S_SEND_STATUS,
        S_WAIT_STATUS,
        S_SEND_DATA,
        S_WAIT_DATA
    } state_t;

endpackage

// File: rtl/uart_dbg_cmd_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_dbg_cmd_ctrl_if
// Bundles the UART word receiver/transmitter handshake and the debug bus
// master port of the command sequencer.
//   rx_ready/rx_word            : received word, one-cycle valid pulse
//   tx_start/tx_word/tx_busy    : word transmit launch and busy feedback
//   mem_rd/mem_wr/mem_addr/
//   mem_wdata/mem_rdata/mem_ack : debug bus request and completion
//   busy                        : sequencer is not idle
// slave  : the sequencer side
// master : the environment side (UART + bus arbiter)
// ---------------------------------------------------------------------------
interface uart_dbg_cmd_ctrl_if;

    logic        rx_ready;
    logic [31:0] rx_word;
    logic        tx_start;
    logic [31:0] tx_word;
    logic        tx_busy;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;

    modport slave (
        input  rx_ready, rx_word, tx_busy, mem_rdata, mem_ack,
        output tx_start, tx_word, mem_rd, mem_wr, mem_addr, mem_wdata, busy
    );

    modport master (
        output rx_ready, rx_word, tx_busy, mem_rdata, mem_ack,
        input  tx_start, tx_word, mem_rd, mem_wr, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/uart_dbg_tx_seq.sv
// ---------------------------------------------------------------------------
// uart_dbg_tx_seq
// Start/busy handshake for launching one word on the UART transmitter.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_send       : owner is in a SEND state and wants to launch i_word
//   i_wait       : owner is in a WAIT state, waiting for the word to finish
//   i_word       : word to launch
//   i_tx_busy    : transmitter busy
//   o_tx_start   : registered one-cycle launch pulse
//   o_tx_word    : registered word, held until the next launch
//   o_fire       : launch happens at this edge (owner moves SEND -> WAIT)
//   o_done       : transmission finished (owner leaves WAIT)
// ---------------------------------------------------------------------------
module uart_dbg_tx_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_send,
    input  logic        i_wait,
    input  logic [31:0] i_word,
    input  logic        i_tx_busy,
    output logic        o_tx_start,
    output logic [31:0] o_tx_word,
    output logic        o_fire,
    output logic        o_done
);

    logic        r_armed;
    logic        r_tx_start;
    logic [31:0] r_tx_word;

    assign o_fire     = i_send & ~i_tx_busy;
    // tx_busy only rises the cycle after tx_start, so the first WAIT cycle
    // sees a stale low; r_armed masks that cycle.
    assign o_done     = i_wait & r_armed & ~i_tx_busy;
    assign o_tx_start = r_tx_start;
    assign o_tx_word  = r_tx_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed    <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_word  <= '0;
        end else begin
            r_armed    <= i_wait;
            r_tx_start <= o_fire;
            if (o_fire) begin
                r_tx_word <= i_word;
            end
        end
    end

endmodule

// File: rtl/uart_dbg_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// uart_dbg_cmd_ctrl
// Command sequencer between the UART word receiver/transmitter and a single
// debug bus master port. Collects a command word (opcode in [31:24]) plus
// address/data operands, issues one bus read or write, and answers with a
// status word followed, for successful reads, by the read data.
// Ports:
//   clk : system clock
//   rst : synchronous, active-high reset (aborts any command silently)
//   bus : uart_dbg_cmd_ctrl_if.slave (UART handshake, bus master, busy)
// Parameters:
//   CLK_RATE         : clock rate in MHz (must be overridden)
//   CMD_TIMEOUT      : ms allowed between words of one command
//   BUS_TIMEOUT_CLKS : clocks allowed waiting for mem_ack
// ---------------------------------------------------------------------------
module uart_dbg_cmd_ctrl
    import uart_dbg_pkg::*;
#(
    parameter int CLK_RATE         = -1,
    parameter int CMD_TIMEOUT      = 200,
    parameter int BUS_TIMEOUT_CLKS = 1024
) (
    input logic                clk,
    input logic                rst,
    uart_dbg_cmd_ctrl_if.slave bus
);

    // Guarded so an un-overridden CLK_RATE still elaborates.
    localparam int WORD_LIMIT = (CLK_RATE > 0) ? CLK_RATE * CMD_TIMEOUT * 1000 : 1;
    localparam int WCNT_W     = $clog2(WORD_LIMIT + 1);
    localparam int BCNT_W     = $clog2(BUS_TIMEOUT_CLKS + 1);

    state_t             r_state;
    logic [7:0]         r_op;
    logic [31:0]        r_status;
    logic [31:0]        r_rdata;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic               r_mem_rd;
    logic               r_mem_wr;
    logic [WCNT_W-1:0]  r_word_cnt;
    logic [BCNT_W-1:0]  r_bus_cnt;

    logic               w_send;
    logic               w_wait;
    logic [31:0]        w_tx_word;
    logic               w_fire;
    logic               w_done;
    logic               w_tx_start;
    logic [31:0]        w_tx_out;

    assign w_send    = (r_state == S_SEND_STATUS) || (r_state == S_SEND_DATA);
    assign w_wait    = (r_state == S_WAIT_STATUS) || (r_state == S_WAIT_DATA);
    assign w_tx_word = (r_state == S_SEND_DATA) ? r_rdata : r_status;

    uart_dbg_tx_seq u_tx_seq (
        .clk        (clk),
        .rst        (rst),
        .i_send     (w_send),
        .i_wait     (w_wait),
        .i_word     (w_tx_word),
        .i_tx_busy  (bus.tx_busy),
        .o_tx_start (w_tx_start),
        .o_tx_word  (w_tx_out),
        .o_fire     (w_fire),
        .o_done     (w_done)
    );

    assign bus.tx_start  = w_tx_start;
    assign bus.tx_word   = w_tx_out;
    assign bus.mem_rd    = r_mem_rd;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_status    <= '0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_word_cnt  <= '0;
            r_bus_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.rx_ready) begin
                        r_op       <= bus.rx_word[31:24];
                        r_word_cnt <= '0;
                        case (bus.rx_word[31:24])
                            OP_PING: begin
                                r_status <= ST_OK;
                                r_state  <= S_SEND_STATUS;
                            end
                            OP_READ, OP_WRITE: r_state <= S_GET_ADDR;
                            default: begin
                                r_status <= ST_BAD_OPCODE;
                                r_state  <= S_SEND_STATUS;
                            end
                        endcase
                    end
                end
                S_GET_ADDR: begin
                    if (bus.rx_ready) begin
                        r_mem_addr <= bus.rx_word;
                        r_word_cnt <= '0;
                        r_bus_cnt  <= '0;
                        r_state    <= (r_op == OP_WRITE) ? S_GET_DATA : S_BUS;
                    end else if (r_word_cnt == WCNT_W'(WORD_LIMIT)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_word_cnt <= r_word_cnt + WCNT_W'(1);
                    end
                end
                S_GET_DATA: begin
                    if (bus.rx_ready) begin
                        r_mem_wdata <= bus.rx_word;
                        r_bus_cnt   <= '0;
                        r_state     <= S_BUS;
                    end else if (r_word_cnt == WCNT_W'(WORD_LIMIT)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_word_cnt <= r_word_cnt + WCNT_W'(1);
                    end
                end
                S_BUS: begin
                    // Ack is checked first so it wins over a coinciding timeout;
                    // an ack before the request is raised is not ours.
                    if (bus.mem_ack && (r_mem_rd || r_mem_wr)) begin
                        if (r_mem_rd) begin
                            r_rdata <= bus.mem_rdata;
                        end
                        r_status <= ST_OK;
                        r_mem_rd <= 1'b0;
                        r_mem_wr <= 1'b0;
                        r_state  <= S_SEND_STATUS;
                    end else if (r_bus_cnt == BCNT_W'(BUS_TIMEOUT_CLKS)) begin
                        r_status <= ST_BUS_TIMEOUT;
                        r_mem_rd <= 1'b0;
                        r_mem_wr <= 1'b0;
                        r_state  <= S_SEND_STATUS;
                    end else begin
                        r_mem_rd  <= (r_op == OP_READ);
                        r_mem_wr  <= (r_op == OP_WRITE);
                        r_bus_cnt <= r_bus_cnt + BCNT_W'(1);
                    end
                end
                S_SEND_STATUS: begin
                    if (w_fire) begin
                        r_state <= S_WAIT_STATUS;
                    end
                end
                S_WAIT_STATUS: begin
                    if (w_done) begin
                        r_state <= ((r_op == OP_READ) && (r_status == ST_OK)) ? S_SEND_DATA : S_IDLE;
                    end
                end
                S_SEND_DATA: begin
                    if (w_fire) begin
                        r_state <= S_WAIT_DATA;
                    end
                end
                S_WAIT_DATA: begin
                    if (w_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_dbg_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_dbg_cmd_ctrl
// Directed bench for uart_dbg_cmd_ctrl. A transmitter model answers each
// tx_start with a few busy cycles and logs the words; a bus monitor counts
// request-high cycles. Scenario tasks drive commands and compare inline.
// ---------------------------------------------------------------------------
module tb_uart_dbg_cmd_ctrl;

    localparam int TX_BUSY_CLKS = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] tx_q[$];
    int          tx_count;
    int          tx_viol;
    int          tx_left;
    logic        tx_prev_busy;
    int          rd_cycles;
    int          wr_cycles;

    uart_dbg_cmd_ctrl_if bus ();

    uart_dbg_cmd_ctrl #(
        .CLK_RATE         (1),
        .CMD_TIMEOUT      (1),
        .BUS_TIMEOUT_CLKS (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter and bus monitor, acting 2 time units after each edge.
    initial begin
        bus.tx_busy  = 1'b0;
        tx_left      = 0;
        tx_prev_busy = 1'b0;
        tx_count     = 0;
        tx_viol      = 0;
        rd_cycles    = 0;
        wr_cycles    = 0;
        forever begin
            @(posedge clk);
            #2;
            tx_prev_busy = bus.tx_busy;
            if (tx_left > 0) begin
                bus.tx_busy = 1'b1;
                tx_left--;
            end else begin
                bus.tx_busy = 1'b0;
            end
            if (bus.tx_start === 1'b1) begin
                if (tx_prev_busy) tx_viol++;
                tx_q.push_back(bus.tx_word);
                tx_count++;
                tx_left = TX_BUSY_CLKS;
            end
            if (bus.mem_rd === 1'b1) rd_cycles++;
            if (bus.mem_wr === 1'b1) wr_cycles++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        bus.rx_ready = 1'b1;
        bus.rx_word  = w;
        tick();
        bus.rx_ready = 1'b0;
        bus.rx_word  = 32'h0;
    endtask

    task automatic wait_idle(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (!bus.busy && !bus.tx_busy && tx_left == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_logs();
        tx_q.delete();
        tx_count  = 0;
        tx_viol   = 0;
        rd_cycles = 0;
        wr_cycles = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if ({bus.tx_start, bus.mem_rd, bus.mem_wr, bus.busy} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl: {tx_start,mem_rd,mem_wr,busy}=%b expected 0000", {bus.tx_start, bus.mem_rd, bus.mem_wr, bus.busy}); end
        checks++; if (bus.tx_word !== 32'h0) begin errors++; $display("FAIL reset_tx_word: got %h expected 00000000", bus.tx_word); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 00000000", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 00000000", bus.mem_wdata); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ping();
        bit ok;
        clear_logs();
        send_word(32'h0000_0000);
        tick();
        checks++; if (bus.tx_start !== 1'b1) begin errors++; $display("FAIL ping_latency: tx_start=%b expected 1 two clks after rx_ready", bus.tx_start); end
        wait_idle(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ping_done: busy=%b expected 0 within 50 clks", bus.busy); end
        checks++; if (tx_count !== 1) begin errors++; $display("FAIL ping_tx_count: got %0d expected 1", tx_count); end
        checks++; if (tx_q.size() != 1 || tx_q[0] !== 32'h0) begin errors++; $display("FAIL ping_tx_word: got %h expected 00000000", tx_q.size() ? tx_q[0] : 32'hx); end
        checks++; if (rd_cycles + wr_cycles !== 0) begin errors++; $display("FAIL ping_no_bus: bus cycles %0d expected 0", rd_cycles + wr_cycles); end
    endtask

    task automatic test_write();
        bit ok;
        int bad;
        clear_logs();
        bad = 0;
        send_word(32'h0200_0000);
        send_word(32'h8000_0010);
        send_word(32'hDEAD_BEEF);
        checks++; if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL write_entry: mem_wr=%b expected 0 in BUS entry cycle", bus.mem_wr); end
        tick();
        checks++; if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 32'h8000_0010 || bus.mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_req: wr=%b addr=%h wdata=%h expected 1 80000010 deadbeef", bus.mem_wr, bus.mem_addr, bus.mem_wdata); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.mem_wr !== 1'b1 || bus.mem_rd !== 1'b0 || bus.mem_addr !== 32'h8000_0010 || bus.mem_wdata !== 32'hDEAD_BEEF) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL write_hold: %0d unstable request cycles, expected 0", bad); end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        checks++; if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL write_release: mem_wr=%b expected 0 after ack", bus.mem_wr); end
        wait_idle(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL write_done: busy=%b expected 0 within 50 clks", bus.busy); end
        checks++; if (wr_cycles !== 5 || rd_cycles !== 0) begin errors++; $display("FAIL write_cycles: wr=%0d rd=%0d expected 5 0", wr_cycles, rd_cycles); end
        checks++; if (tx_q.size() != 1 || tx_q[0] !== 32'h0) begin errors++; $display("FAIL write_status: %0d words, first %h, expected 1 word 00000000", tx_q.size(), tx_q.size() ? tx_q[0] : 32'hx); end
    endtask

    task automatic test_read();
        bit ok;
        clear_logs();
        send_word(32'h0100_0000);
        send_word(32'h0000_1000);
        tick();
        checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL read_req: rd=%b addr=%h expected 1 00001000", bus.mem_rd, bus.mem_addr); end
        bus.mem_rdata = 32'h1234_5678;
        bus.mem_ack   = 1'b1;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL read_release: mem_rd=%b expected 0 after ack", bus.mem_rd); end
        wait_idle(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL read_done: busy=%b expected 0 within 100 clks", bus.busy); end
        checks++; if (tx_q.size() != 2) begin errors++; $display("FAIL read_tx_count: got %0d expected 2", tx_q.size()); end
        checks++; if (tx_q.size() != 2 || tx_q[0] !== 32'h0 || tx_q[1] !== 32'h1234_5678) begin errors++; $display("FAIL read_tx_words: got %h %h expected 00000000 12345678", tx_q.size() > 0 ? tx_q[0] : 32'hx, tx_q.size() > 1 ? tx_q[1] : 32'hx); end
        checks++; if (tx_viol !== 0) begin errors++; $display("FAIL read_tx_handshake: %0d starts while tx_busy, expected 0", tx_viol); end
        checks++; if (rd_cycles !== 1 || wr_cycles !== 0) begin errors++; $display("FAIL read_cycles: rd=%0d wr=%0d expected 1 0", rd_cycles, wr_cycles); end
    endtask

    task automatic test_bus_timeout();
        bit ok;
        clear_logs();
        send_word(32'h0100_0000);
        send_word(32'h0000_0020);
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bto_done: busy=%b expected 0 within 200 clks", bus.busy); end
        checks++; if (rd_cycles !== 16) begin errors++; $display("FAIL bto_rd_cycles: got %0d expected 16", rd_cycles); end
        checks++; if (tx_q.size() != 1 || tx_q[0] !== 32'h2) begin errors++; $display("FAIL bto_status: %0d words, first %h, expected 1 word 00000002", tx_q.size(), tx_q.size() ? tx_q[0] : 32'hx); end
    endtask

    task automatic test_bad_opcode();
        bit ok;
        clear_logs();
        send_word(32'h7F00_0000);
        wait_idle(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL badop_done: busy=%b expected 0 within 50 clks", bus.busy); end
        checks++; if (tx_q.size() != 1 || tx_q[0] !== 32'h1) begin errors++; $display("FAIL badop_status: %0d words, first %h, expected 1 word 00000001", tx_q.size(), tx_q.size() ? tx_q[0] : 32'hx); end
        checks++; if (rd_cycles + wr_cycles !== 0) begin errors++; $display("FAIL badop_no_bus: bus cycles %0d expected 0", rd_cycles + wr_cycles); end
    endtask

    task automatic test_cmd_timeout();
        bit ok;
        clear_logs();
        send_word(32'h0200_0000);
        send_word(32'h0000_0040);
        repeat (990) tick();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL cto_early: busy=%b expected 1 before 1000 clks", bus.busy); end
        repeat (110) tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cto_expire: busy=%b expected 0 after 1100 clks", bus.busy); end
        checks++; if (tx_count !== 0 || wr_cycles !== 0) begin errors++; $display("FAIL cto_silent: tx=%0d wr=%0d expected 0 0", tx_count, wr_cycles); end
        send_word(32'h0000_0000);
        wait_idle(50, ok);
        checks++; if (!ok || tx_q.size() != 1 || tx_q[0] !== 32'h0) begin errors++; $display("FAIL cto_ping_after: ok=%b %0d words, expected 1 word 00000000", ok, tx_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        clear_logs();
        send_word(32'h0100_0000);
        send_word(32'h0000_0044);
        tick();
        checks++; if (bus.mem_rd !== 1'b1) begin errors++; $display("FAIL rstbus_pre: mem_rd=%b expected 1", bus.mem_rd); end
        rst = 1'b1;
        tick();
        checks++; if ({bus.mem_rd, bus.mem_wr, bus.busy, bus.tx_start} !== 4'b0000 || bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rstbus_clear: {rd,wr,busy,start}=%b addr=%h expected 0000 00000000", {bus.mem_rd, bus.mem_wr, bus.busy, bus.tx_start}, bus.mem_addr); end
        rst = 1'b0;
        repeat (30) tick();
        checks++; if (tx_count !== 0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rstbus_silent: tx=%0d busy=%b expected 0 0", tx_count, bus.busy); end

        send_word(32'h0100_0000);
        send_word(32'h0000_0048);
        tick();
        bus.mem_rdata = 32'hCAFE_F00D;
        bus.mem_ack   = 1'b1;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.tx_start === 1'b1 && bus.tx_word === 32'hCAFE_F00D) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rstdata_reach: data word cafef00d not launched within 60 clks"); end
        rst = 1'b1;
        tick();
        checks++; if ({bus.tx_start, bus.busy, bus.mem_rd, bus.mem_wr} !== 4'b0000 || bus.tx_word !== 32'h0) begin errors++; $display("FAIL rstdata_clear: {start,busy,rd,wr}=%b tx_word=%h expected 0000 00000000", {bus.tx_start, bus.busy, bus.mem_rd, bus.mem_wr}, bus.tx_word); end
        rst = 1'b0;
        wait_idle(50, ok);
        checks++; if (!ok || tx_count !== 2) begin errors++; $display("FAIL rstdata_after: ok=%b tx=%0d expected 1 2", ok, tx_count); end
    endtask

    task automatic test_extra_rx();
        bit ok;
        clear_logs();
        send_word(32'h0000_0000);
        tick();
        send_word(32'h0000_0000);
        wait_idle(50, ok);
        repeat (20) tick();
        checks++; if (!ok || tx_count !== 1 || bus.busy !== 1'b0) begin errors++; $display("FAIL extra_rx_ignored: ok=%b tx=%0d busy=%b expected 1 1 0", ok, tx_count, bus.busy); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.rx_ready  = 1'b0;
        bus.rx_word   = 32'h0;
        bus.mem_rdata = 32'h0;
        bus.mem_ack   = 1'b0;
        test_reset();
        test_ping();
        test_write();
        test_read();
        test_bus_timeout();
        test_bad_opcode();
        test_cmd_timeout();
        test_reset_mid();
        test_extra_rx();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_dbg_cmd_ctrl.md
Name: uart_dbg_cmd_ctrl

Overview:
- Command sequencer between the UART word receiver (32-bit words, one-shot ready) and a single debug bus master port.
- Collects a command word plus its address/data operand words, then issues one bus read or write.
- Returns a status word, plus read data for reads, through the UART word transmitter.
- Sits on the debugger side, feeding the target memory/MMIO arbiter.

Parameters:
- CLK_RATE, -1, clk rate in MHz; must be overridden.
- CMD_TIMEOUT, 200, max ms between words of one command before the partial command is discarded.
- BUS_TIMEOUT_CLKS, 1024, max clks waiting for mem_ack before a bus error is reported.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_ready  in  1  one-cycle pulse; rx_word valid this cycle
- rx_word  in  32  received word, big-endian assembled
- tx_start  out  1  one-cycle pulse; launch tx_word
- tx_word  out  32  word to transmit; held stable until tx_busy falls
- tx_busy  in  1  transmitter busy; high from the cycle after tx_start until the word is sent
- mem_rd  out  1  bus read request; level, held until ack or timeout
- mem_wr  out  1  bus write request; level, held until ack or timeout
- mem_addr  out  32  bus address
- mem_wdata  out  32  bus write data
- mem_rdata  in  32  read data; valid when mem_ack=1
- mem_ack  in  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; internal registers cleared. Reset mid-command or mid-transfer aborts immediately with no response. mem_rd and mem_wr drop the next edge.
- Command word format:
  - opcode = rx_word[31:24]: 0x01 READ, 0x02 WRITE, 0x00 PING.
  - rx_word[23:0] ignored.
- States and transitions:
  - IDLE: on rx_ready, latch the opcode. PING goes to SEND_STATUS with status OK. READ or WRITE goes to GET_ADDR. Any other opcode goes to SEND_STATUS with BAD_OPCODE.
  - GET_ADDR: on rx_ready, latch mem_addr. WRITE goes to GET_DATA; READ goes to BUS.
  - GET_DATA: on rx_ready, latch mem_wdata, then go to BUS.
  - Inter-word timeout (GET_ADDR/GET_DATA): word timer counts clks since entry or since the last accepted word. When it reaches CLK_RATE*CMD_TIMEOUT*1000, return to IDLE; nothing is transmitted.
  - BUS: assert mem_rd (READ) or mem_wr (WRITE) starting the cycle after entry.
    - On mem_ack: capture mem_rdata (READ only), status OK, deassert the request the next cycle, go to SEND_STATUS.
    - If the bus counter reaches BUS_TIMEOUT_CLKS with no ack: status BUS_TIMEOUT, go to SEND_STATUS.
    - If mem_ack and timeout coincide, the ack wins.
  - SEND_STATUS: when tx_busy=0, pulse tx_start with tx_word=status, go to WAIT_STATUS.
  - WAIT_STATUS: ignore tx_busy in the first cycle. Afterwards, on tx_busy=0: READ with status OK goes to SEND_DATA; everything else goes to IDLE.
  - SEND_DATA / WAIT_DATA: same handshake, tx_word=read data, then IDLE.
- Status codes: 0x00000000 OK, 0x00000001 BAD_OPCODE, 0x00000002 BUS_TIMEOUT.
- rx_ready while in BUS, SEND_*, or WAIT_*: the word is dropped silently, with no queueing.
- Latency:
  - PING: tx_start 2 clks after rx_ready (IDLE→SEND_STATUS, then pulse), assuming tx idle.
  - READ: mem_rd is high 1 clk after entering BUS.
- Bus outputs: mem_addr and mem_wdata are registered and stable for the whole request.
- Counters: sized $clog2(limit+1); no wrap-around is possible.

Decomposition:
- Package uart_dbg_pkg holds:
  - opcode localparams (OP_PING/OP_READ/OP_WRITE);
  - status localparams (ST_OK/ST_BAD_OPCODE/ST_BUS_TIMEOUT);
  - the state enum typedef.
- One natural sub-module: uart_dbg_tx_seq, the start/busy handshake for a single word, reused for status and data.
- Timers stay inline.

Test Plan:
- PING (0x00000000) -> exactly one tx_start, tx_word=0x00000000; busy returns to 0; mem_rd and mem_wr never assert.
- WRITE 0x02000000, 0x80000010, 0xDEADBEEF; ack after 5 clks -> mem_wr high with addr 0x80000010 and wdata 0xDEADBEEF until ack; one tx word 0x00000000.
- READ 0x01000000, 0x00001000; mem_rdata=0x12345678 with ack -> tx words 0x00000000 then 0x12345678, in order, each tx_start only when tx_busy=0.
- READ with no ack (BUS_TIMEOUT_CLKS=16) -> mem_rd high exactly 16 clks then low; tx word 0x00000002 only, no data word.
- Opcode 0x7F000000 -> tx 0x00000001, no bus activity. Separately, WRITE cmd+addr then silence past CMD_TIMEOUT (CLK_RATE=1, CMD_TIMEOUT=1) -> no tx; a following PING is answered normally.
- rst asserted mid-BUS and mid-WAIT_DATA -> all outputs 0 next edge; an extra rx_ready during WAIT_STATUS is ignored with no extra response.
